pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control and status unit for the five-stage Y86-64 core (F/D/E/M/W).
- Combinationally generates per-stage stall/bubble and condition-code write-enable from the hazard state of the stage registers.
- Sequentially tracks machine status (RUN/HALTED/FAULT), enforces a retirement watchdog, and keeps saturating performance counters.
- Replaces the top-level's ad hoc stat handling and $finish with a synthesizable, parametrised controller.

Parameters:
- CNT_W, 32, width of each performance counter.
- WDOG_W, 16, width of the watchdog counter.
- WDOG_LIMIT, 1000, cycles in RUN with no retirement before FAULT; 0 disables the watchdog.
- REG_W, 4, register-ID width; RNONE is all-ones.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- D_icode  in  4  icode in the D register.
- d_srcA  in  REG_W  decode source A ID.
- d_srcB  in  REG_W  decode source B ID.
- E_icode  in  4  icode in the E register.
- E_dstM  in  REG_W  memory destination in E.
- e_cnd  in  1  branch/cmov condition from execute.
- M_icode  in  4  icode in the M register.
- m_stat  in  3  memory-stage status.
- W_icode  in  4  icode in the W register.
- W_stat  in  3  writeback status.
- F_stall  out  1  hold the F register.
- D_stall  out  1  hold the D register.
- D_bubble  out  1  load a nop into D.
- E_bubble  out  1  load a nop into E.
- M_bubble  out  1  load a nop into M.
- W_stall  out  1  hold the W register.
- set_cc  out  1  condition-code write enable.
- halted  out  1  machine halted normally.
- fault  out  1  machine stopped on an exception or watchdog.
- fault_stat  out  3  latched W_stat at the fault; 7 = watchdog.
- cyc_cnt  out  CNT_W  cycles spent in RUN.
- ret_cnt  out  CNT_W  instructions retired.
- lu_cnt  out  CNT_W  load-use stall events.
- mp_cnt  out  CNT_W  branch mispredicts.

Behaviour:
- Encodings:
  - Status: AOK=1, HLT=2, ADR=3, INS=4.
  - icodes: HALT=0, NOP=1, JXX=7, OPQ=6, MRMOVQ=5, POPQ=B, RET=9.
- Hazard terms, combinational:
  - loaduse = E_icode∈{5,B} && E_dstM!=RNONE && E_dstM∈{d_srcA,d_srcB}.
  - mispred = E_icode==7 && !e_cnd.
  - retp = RET present in D, E or M.
  - exc_m = m_stat!=AOK.
  - exc_w = W_stat!=AOK.
- Outputs in RUN, combinational, same cycle:
  - F_stall = loaduse | retp.
  - D_stall = loaduse.
  - D_bubble = mispred | (retp & !loaduse).
  - E_bubble = mispred | loaduse.
  - M_bubble = exc_m | exc_w.
  - W_stall = exc_w.
  - set_cc = E_icode==6 & !exc_m & !exc_w.
- Priority: loaduse overrides the ret bubble, so D_stall and D_bubble are never both 1.
- While rst_n=0 (the outputs drive these values combinationally in the reset cycle):
  - D_bubble=E_bubble=M_bubble=1.
  - All stalls and set_cc = 0.
  - This flushes the pipeline with nops.
- State machine, registered, resets to RUN:
  - RUN→HALTED when W_stat==HLT.
  - RUN→FAULT when W_stat∈{ADR,INS}; fault_stat latches W_stat.
  - RUN→FAULT when WDOG_LIMIT!=0 and the watchdog reaches WDOG_LIMIT; fault_stat=7.
  - If W_stat faults on the same cycle the watchdog expires, the W_stat fault wins.
  - HALTED and FAULT are sticky until reset.
- In HALTED/FAULT:
  - F_stall=D_stall=W_stall=1, all bubbles 0, set_cc=0 (pipeline frozen).
  - Counters hold.
- halted=(state==HALTED) and fault=(state==FAULT), both registered.
- Register reset values:
  - halted=0, fault=0, fault_stat=1.
  - All counters 0, watchdog 0.
- Watchdog:
  - Increments each RUN cycle.
  - Clears on any retire.
  - Saturates at the WDOG_W maximum.
- Counters update only in RUN and saturate at 2^CNT_W-1 (no wrap):
  - cyc_cnt +1 every cycle.
  - ret_cnt +1 when W_stat==AOK && W_icode!=NOP && !W_stall.
  - lu_cnt +1 per cycle with loaduse.
  - mp_cnt +1 per cycle with mispred.
- Reset mid-operation: on the next edge, the state, flags and all counters return to their reset values, whatever state the machine was in.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0, and lu_cnt 0→1 after the edge. With E_dstM=F, all are 0.
- Mispredict: E_icode=7, e_cnd=0 → D_bubble=E_bubble=1, F_stall=0, mp_cnt+1. With e_cnd=1, no bubble.
- Return: D_icode=9 for 3 cycles as it moves through D, E and M → F_stall=D_bubble=1 each cycle.
  - Return combined with load-use (loaduse=1) → D_stall=1, D_bubble=0.
- Halt: W_stat=2 → halted=1 next cycle; cyc_cnt frozen; F_stall=D_stall=W_stall=1. Reset for 1 cycle → halted=0, cyc_cnt=0.
- Exception: m_stat=3 → M_bubble=1, set_cc=0 with E_icode=6. Next cycle W_stat=3 → fault=1, fault_stat=3.
- Watchdog (WDOG_LIMIT=4, CNT_W=3): no retire for 4 cycles → fault=1, fault_stat=7. Separately, 10 retires → ret_cnt saturates at 7.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - pipeline control and status unit for the five-stage Y86-64 core.
//
// Combinationally derives per-stage stall/bubble controls and the
// condition-code write enable from the hazard state of the stage registers.
// Sequentially tracks machine status (RUN/HALTED/FAULT), runs a retirement
// watchdog, and keeps saturating performance counters.
//
// Ports:
//   clk, rst_n                 rising-edge clock, synchronous active-low reset
//   D_icode, d_srcA, d_srcB    decode-stage icode and source register IDs
//   E_icode, E_dstM, e_cnd     execute-stage icode, load destination, condition
//   M_icode, m_stat            memory-stage icode and status
//   W_icode, W_stat            writeback-stage icode and status
//   F_stall, D_stall, W_stall  hold the F / D / W registers
//   D_bubble, E_bubble, M_bubble  load a nop into D / E / M
//   set_cc                     condition-code write enable
//   halted, fault, fault_stat  machine status; fault_stat=7 means watchdog
//   cyc_cnt, ret_cnt, lu_cnt, mp_cnt  saturating performance counters
module pipe_ctrl #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WDOG_W     = 16,
    parameter int unsigned WDOG_LIMIT = 1000,
    parameter int unsigned REG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [REG_W-1:0] d_srcA,
    input  logic [REG_W-1:0] d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [REG_W-1:0] E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic             fault,
    output logic [2:0]       fault_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam logic [2:0] S_AOK  = 3'd1;
    localparam logic [2:0] S_HLT  = 3'd2;
    localparam logic [2:0] S_ADR  = 3'd3;
    localparam logic [2:0] S_INS  = 3'd4;
    localparam logic [2:0] S_WDOG = 3'd7;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [REG_W-1:0] RNONE = '1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_FAULT
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        fstat_nxt;
    logic [WDOG_W-1:0] wdog, wdog_nxt;
    logic              loaduse, mispred, retp, exc_m, exc_w;
    logic              retire, wd_expire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                  (E_dstM != RNONE) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mispred = (E_icode == I_JXX) && !e_cnd;
        retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        exc_m   = (m_stat != S_AOK);
        exc_w   = (W_stat != S_AOK);
        // W_stall is exc_w in RUN, so it can never block an AOK retire; leaving
        // it out keeps retire off the output/next-state loop below.
        retire  = (W_stat == S_AOK) && (W_icode != I_NOP);
        if (retire)
            wdog_nxt = '0;
        else if (wdog == '1)
            wdog_nxt = wdog;
        else
            wdog_nxt = wdog + WDOG_W'(1);
        wd_expire = (WDOG_LIMIT != 0) && (32'(wdog_nxt) >= WDOG_LIMIT);
    end

    always_comb begin
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        W_stall   = 1'b0;
        set_cc    = 1'b0;
        state_nxt = state;
        fstat_nxt = fault_stat;
        if (!rst_n) begin
            // flush the pipeline with nops while reset is held
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    F_stall  = loaduse | retp;
                    D_stall  = loaduse;
                    D_bubble = mispred | (retp & !loaduse);
                    E_bubble = mispred | loaduse;
                    M_bubble = exc_m | exc_w;
                    W_stall  = exc_w;
                    set_cc   = (E_icode == I_OPQ) & !exc_m & !exc_w;
                    if (W_stat == S_HLT) begin
                        state_nxt = ST_HALTED;
                    end else if ((W_stat == S_ADR) || (W_stat == S_INS)) begin
                        state_nxt = ST_FAULT;
                        fstat_nxt = W_stat;
                    end else if (wd_expire) begin
                        state_nxt = ST_FAULT;
                        fstat_nxt = S_WDOG;
                    end
                end
                default: begin
                    F_stall = 1'b1;
                    D_stall = 1'b1;
                    W_stall = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            fault_stat <= S_AOK;
            wdog       <= '0;
            cyc_cnt    <= '0;
            ret_cnt    <= '0;
            lu_cnt     <= '0;
            mp_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            fault_stat <= fstat_nxt;
            if (state == ST_RUN) begin
                wdog    <= wdog_nxt;
                cyc_cnt <= sat_inc(cyc_cnt);
                if (retire)
                    ret_cnt <= sat_inc(ret_cnt);
                if (loaduse)
                    lu_cnt <= sat_inc(lu_cnt);
                if (mispred)
                    mp_cnt <= sat_inc(mp_cnt);
            end
        end
    end

    assign halted = (state == ST_HALTED);
    assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl - bench for pipe_ctrl. Two instances share the stage inputs:
// "a" with default parameters and "b" with CNT_W=3, WDOG_LIMIT=4, each with
// its own reset. A behavioural reference model tracks both.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [3:0] D_icode;
        logic [3:0] d_srcA;
        logic [3:0] d_srcB;
        logic [3:0] E_icode;
        logic [3:0] E_dstM;
        logic       e_cnd;
        logic [3:0] M_icode;
        logic [2:0] m_stat;
        logic [3:0] W_icode;
        logic [2:0] W_stat;
    } in_t;

    // expected comb bits: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    typedef struct {
        string      nm;
        in_t        v;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        int         mode;   // 0 running, 1 halted, 2 faulted
        logic [2:0] fstat;
        longint     cyc, ret, lu, mp, wd;
    } mdl_t;

    localparam logic [6:0] OUT_RST    = 7'b0011100;
    localparam logic [6:0] OUT_FROZEN = 7'b1100010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    in_t  vin;

    logic        a_F_stall, a_D_stall, a_D_bubble, a_E_bubble, a_M_bubble, a_W_stall, a_set_cc;
    logic        a_halted, a_fault;
    logic [2:0]  a_fault_stat;
    logic [31:0] a_cyc, a_ret, a_lu, a_mp;
    logic        b_F_stall, b_D_stall, b_D_bubble, b_E_bubble, b_M_bubble, b_W_stall, b_set_cc;
    logic        b_halted, b_fault;
    logic [2:0]  b_fault_stat;
    logic [2:0]  b_cyc, b_ret, b_lu, b_mp;
    logic [6:0]  a_co, b_co;

    assign a_co = {a_F_stall, a_D_stall, a_D_bubble, a_E_bubble, a_M_bubble, a_W_stall, a_set_cc};
    assign b_co = {b_F_stall, b_D_stall, b_D_bubble, b_E_bubble, b_M_bubble, b_W_stall, b_set_cc};

    pipe_ctrl u_a (
        .clk(clk), .rst_n(rst_a),
        .D_icode(vin.D_icode), .d_srcA(vin.d_srcA), .d_srcB(vin.d_srcB),
        .E_icode(vin.E_icode), .E_dstM(vin.E_dstM), .e_cnd(vin.e_cnd),
        .M_icode(vin.M_icode), .m_stat(vin.m_stat),
        .W_icode(vin.W_icode), .W_stat(vin.W_stat),
        .F_stall(a_F_stall), .D_stall(a_D_stall), .D_bubble(a_D_bubble),
        .E_bubble(a_E_bubble), .M_bubble(a_M_bubble), .W_stall(a_W_stall),
        .set_cc(a_set_cc), .halted(a_halted), .fault(a_fault), .fault_stat(a_fault_stat),
        .cyc_cnt(a_cyc), .ret_cnt(a_ret), .lu_cnt(a_lu), .mp_cnt(a_mp)
    );

    pipe_ctrl #(.CNT_W(3), .WDOG_W(16), .WDOG_LIMIT(4), .REG_W(4)) u_b (
        .clk(clk), .rst_n(rst_b),
        .D_icode(vin.D_icode), .d_srcA(vin.d_srcA), .d_srcB(vin.d_srcB),
        .E_icode(vin.E_icode), .E_dstM(vin.E_dstM), .e_cnd(vin.e_cnd),
        .M_icode(vin.M_icode), .m_stat(vin.m_stat),
        .W_icode(vin.W_icode), .W_stat(vin.W_stat),
        .F_stall(b_F_stall), .D_stall(b_D_stall), .D_bubble(b_D_bubble),
        .E_bubble(b_E_bubble), .M_bubble(b_M_bubble), .W_stall(b_W_stall),
        .set_cc(b_set_cc), .halted(b_halted), .fault(b_fault), .fault_stat(b_fault_stat),
        .cyc_cnt(b_cyc), .ret_cnt(b_ret), .lu_cnt(b_lu), .mp_cnt(b_mp)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [3:0] di, sa, sb, ei, edm, input logic ec,
                               input logic [3:0] mi, input logic [2:0] ms,
                               input logic [3:0] wi, input logic [2:0] ws);
        in_t v;
        v.D_icode = di; v.d_srcA = sa; v.d_srcB = sb;
        v.E_icode = ei; v.E_dstM = edm; v.e_cnd = ec;
        v.M_icode = mi; v.m_stat = ms; v.W_icode = wi; v.W_stat = ws;
        return v;
    endfunction

    function automatic in_t idle();
        return mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 4'h1, 3'd1);
    endfunction

    // ---------------- reference model ----------------
    function automatic longint inc_sat(input longint x, input longint mx);
        return (x >= mx) ? mx : x + 1;
    endfunction

    function automatic logic [6:0] mcomb(input int mode, input logic rst, input in_t v);
        logic lu, mp, rp, em, ew;
        if (!rst) return OUT_RST;
        if (mode != 0) return OUT_FROZEN;
        lu = (v.E_icode inside {4'h5, 4'hB}) && v.E_dstM != 4'hF &&
             (v.E_dstM == v.d_srcA || v.E_dstM == v.d_srcB);
        mp = (v.E_icode == 4'h7) && !v.e_cnd;
        rp = (v.D_icode == 4'h9) || (v.E_icode == 4'h9) || (v.M_icode == 4'h9);
        em = (v.m_stat != 3'd1);
        ew = (v.W_stat != 3'd1);
        return {lu | rp, lu, mp | (rp & !lu), mp | lu, em | ew, ew,
                (v.E_icode == 4'h6) & !em & !ew};
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic rst, input in_t v,
                                   input longint cmax, input longint wlim);
        mdl_t  n;
        logic [6:0] o;
        logic  ret_ok;
        n = m;
        if (!rst) begin
            n.mode = 0; n.fstat = 3'd1;
            n.cyc = 0; n.ret = 0; n.lu = 0; n.mp = 0; n.wd = 0;
            return n;
        end
        if (m.mode != 0) return n;
        o = mcomb(0, 1'b1, v);
        ret_ok = (v.W_stat == 3'd1) && (v.W_icode != 4'h1) && !o[1];
        n.cyc = inc_sat(m.cyc, cmax);
        if (ret_ok) n.ret = inc_sat(m.ret, cmax);
        if (o[5])   n.lu  = inc_sat(m.lu, cmax);
        if (o[3] && !o[5]) n.mp = inc_sat(m.mp, cmax);
        n.wd = ret_ok ? 0 : inc_sat(m.wd, 65535);
        if (v.W_stat == 3'd2)
            n.mode = 1;
        else if (v.W_stat == 3'd3 || v.W_stat == 3'd4) begin
            n.mode = 2; n.fstat = v.W_stat;
        end else if (wlim != 0 && n.wd >= wlim) begin
            n.mode = 2; n.fstat = 3'd7;
        end
        return n;
    endfunction

    mdl_t mA, mB;
    always @(posedge clk) begin
        mA = mstep(mA, rst_a, vin, 64'd4294967295, 1000);
        mB = mstep(mB, rst_b, vin, 7, 4);
    end

    task automatic chk_regs(input string tag, input mdl_t m, input logic h, f,
                            input logic [2:0] fs, input logic [63:0] c, r, l, p);
        chk({tag, "_halted"}, h, m.mode == 1);
        chk({tag, "_fault"}, f, m.mode == 2);
        chk({tag, "_fault_stat"}, fs, m.fstat);
        chk({tag, "_cyc"}, c, m.cyc);
        chk({tag, "_ret"}, r, m.ret);
        chk({tag, "_lu"}, l, m.lu);
        chk({tag, "_mp"}, p, m.mp);
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_both();
        rst_a = 1'b0; rst_b = 1'b0; vin = idle();
        tick();
        rst_a = 1'b1; rst_b = 1'b1;
    endtask

    function automatic logic [3:0] ric();
        case ($urandom_range(0, 7))
            0: return 4'h0;
            1: return 4'h1;
            2: return 4'h5;
            3: return 4'h6;
            4: return 4'h7;
            5: return 4'h9;
            6: return 4'hB;
            default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] rreg();
        int unsigned r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    function automatic in_t rnd_vec();
        logic [2:0] ms, ws;
        ms = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
        ws = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
        return mk(ric(), rreg(), rreg(), ric(), rreg(), 1'($urandom_range(0, 1)),
                  ric(), ms, ric(), ws);
    endfunction

    vec_t tbl[14];

    initial begin
        #1000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{"lu_srcA",    mk(4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b1101000};
        tbl[1]  = '{"lu_rnone",   mk(4'h6, 4'h3, 4'hF, 4'h5, 4'hF, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b0000000};
        tbl[2]  = '{"lu_popq_b",  mk(4'h6, 4'h2, 4'h4, 4'hB, 4'h4, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b1101000};
        tbl[3]  = '{"mispred",    mk(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 0, 4'h1, 3'd1, 4'h1, 3'd1), 7'b0011000};
        tbl[4]  = '{"jxx_taken",  mk(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b0000000};
        tbl[5]  = '{"ret_d",      mk(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b1010000};
        tbl[6]  = '{"ret_e",      mk(4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b1010000};
        tbl[7]  = '{"ret_m",      mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h9, 3'd1, 4'h1, 3'd1), 7'b1010000};
        tbl[8]  = '{"ret_lu",     mk(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b1101000};
        tbl[9]  = '{"opq_cc",     mk(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b0000001};
        tbl[10] = '{"opq_exc_m",  mk(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1, 4'h1, 3'd3, 4'h1, 3'd1), 7'b0000100};
        tbl[11] = '{"opq_exc_w",  mk(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1, 4'h1, 3'd1, 4'h5, 3'd4), 7'b0000110};
        tbl[12] = '{"mp_ret_m",   mk(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 0, 4'h9, 3'd1, 4'h1, 3'd1), 7'b1011000};
        tbl[13] = '{"mrm_nomatch",mk(4'h6, 4'h2, 4'h4, 4'h5, 4'h3, 1, 4'h1, 3'd1, 4'h1, 3'd1), 7'b0000000};

        // reset cycle: flush outputs, then reset register values
        rst_a = 1'b0; rst_b = 1'b0; vin = idle();
        #2;
        chk("rst_comb_a", a_co, OUT_RST);
        chk("rst_comb_b", b_co, OUT_RST);
        tick();
        chk("rst_comb_a2", a_co, OUT_RST);
        chk("rst_halted", a_halted, 1'b0);
        chk("rst_fault", a_fault, 1'b0);
        chk("rst_fault_stat", a_fault_stat, 3'd1);
        chk("rst_cyc", a_cyc, 0);
        chk("rst_ret", a_ret, 0);
        chk("rst_lu", a_lu, 0);
        chk("rst_mp", a_mp, 0);
        rst_a = 1'b1; rst_b = 1'b1;

        // combinational table; inputs return to idle before each edge
        foreach (tbl[i]) begin
            vin = tbl[i].v;
            #2;
            chk({"tbl_", tbl[i].nm}, a_co, tbl[i].exp);
            vin = idle();
            tick();
        end

        // load-use, mispredict and return sequences
        reset_both();
        vin = tbl[0].v;
        #2;
        chk("lu_before", a_lu, 0);
        tick();
        chk("lu_after", a_lu, 1);
        vin = tbl[1].v;
        tick();
        chk("lu_rnone_hold", a_lu, 1);
        vin = tbl[3].v;
        #2;
        chk("mp_comb", a_co, 7'b0011000);
        tick();
        chk("mp_after", a_mp, 1);
        vin = tbl[4].v;
        tick();
        chk("mp_taken_hold", a_mp, 1);
        for (int k = 0; k < 3; k++) begin
            vin = idle();
            if (k == 0) vin.D_icode = 4'h9;
            if (k == 1) vin.E_icode = 4'h9;
            if (k == 2) vin.M_icode = 4'h9;
            #2;
            chk("ret_fstall", a_F_stall, 1'b1);
            chk("ret_dbubble", a_D_bubble, 1'b1);
            tick();
        end
        vin = idle();
        chk("seq_cyc7", a_cyc, 7);
        chk("seq_ret0", a_ret, 0);

        // halt, freeze, reset out of it
        reset_both();
        tick();
        tick();
        vin = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h1, 3'd1, 4'h0, 3'd2);
        tick();
        vin = idle();
        chk("halt_halted", a_halted, 1'b1);
        chk("halt_cyc", a_cyc, 3);
        tick(); tick(); tick();
        chk("halt_cyc_frozen", a_cyc, 3);
        chk("halt_comb", a_co, OUT_FROZEN);
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        chk("halt_rst_halted", a_halted, 1'b0);
        chk("halt_rst_cyc", a_cyc, 0);

        // memory exception then writeback fault
        reset_both();
        vin = tbl[10].v;
        #2;
        chk("exc_mbubble", a_M_bubble, 1'b1);
        chk("exc_setcc", a_set_cc, 1'b0);
        tick();
        vin = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h1, 3'd1, 4'h5, 3'd3);
        tick();
        vin = idle();
        chk("exc_fault", a_fault, 1'b1);
        chk("exc_fault_stat", a_fault_stat, 3'd3);
        chk("exc_halted", a_halted, 1'b0);
        tick();
        chk("exc_frozen_comb", a_co, OUT_FROZEN);
        chk("exc_cyc", a_cyc, 2);

        // watchdog on the small instance
        reset_both();
        tick(); tick(); tick();
        chk("wd_not_yet", b_fault, 1'b0);
        tick();
        chk("wd_fault", b_fault, 1'b1);
        chk("wd_fault_stat", b_fault_stat, 3'd7);
        reset_both();
        tick(); tick(); tick();
        vin = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h1, 3'd1, 4'h5, 3'd4);
        tick();
        vin = idle();
        chk("wd_tie_fault", b_fault, 1'b1);
        chk("wd_tie_stat", b_fault_stat, 3'd4);
        reset_both();
        vin = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 4'h1, 3'd1, 4'h6, 3'd1);
        for (int k = 0; k < 10; k++) tick();
        vin = idle();
        chk("sat_ret", b_ret, 3'd7);
        chk("sat_cyc", b_cyc, 3'd7);
        chk("sat_nofault", b_fault, 1'b0);

        // randomized run against the model
        reset_both();
        for (int unsigned i = 0; i < 600; i++) begin
            rst_a = ($urandom_range(0, 29) != 0);
            rst_b = ($urandom_range(0, 19) != 0);
            vin = rnd_vec();
            #2;
            chk("rnd_comb_a", a_co, mcomb(mA.mode, rst_a, vin));
            chk("rnd_comb_b", b_co, mcomb(mB.mode, rst_b, vin));
            chk("rnd_dstall_dbub", a_D_stall & a_D_bubble, 1'b0);
            tick();
            chk_regs("rnd_a", mA, a_halted, a_fault, a_fault_stat, a_cyc, a_ret, a_lu, a_mp);
            chk_regs("rnd_b", mB, b_halted, b_fault, b_fault_stat, b_cyc, b_ret, b_lu, b_mp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
